// File: rtl/audio_i2s_stream_if.sv
// I2S / left-justified serial port with stereo RX/TX FIFOs and valid/ready streams.
// Serial pins are asynchronous to clk_clk and are resynchronised before use.
module audio_i2s_stream_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a push when the same cycle frees a slot
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

module audio_i2s_stream_if #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int JUSTIFY    = 0
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          aud_bclk,
    input  logic                          aud_adclrc,
    input  logic                          aud_daclrc,
    input  logic                          aud_adcdat,
    output logic                          aud_dacdat,
    input  logic                          enable,
    input  logic                          clear_flags,
    output logic [2*DATA_W-1:0]           rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [2*DATA_W-1:0]           tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          rx_overflow,
    output logic                          tx_underflow
);
    localparam int FW = 2 * DATA_W;
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LEFT, ST_RIGHT} state_e;

    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0] sync3_q, sync3_d;
    logic       bclk_rise, bclk_fall, adc_rise, adc_fall;
    logic       dac_rise, dac_fall, adc_bit;

    state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic              rx_skip_q, rx_skip_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d, rx_left_q, rx_left_d;
    logic [FW-1:0]     rx_frame_q, rx_frame_d;
    logic              rx_push_q, rx_push_d;
    logic              rx_restart, rx_sample;

    state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, tx_right_q, tx_right_d, tx_word;
    logic              dacdat_q, dacdat_d;
    logic              tx_start, tx_load, tx_shift, tx_unf_ev;

    logic              rx_overflow_q, rx_overflow_d;
    logic              tx_underflow_q, tx_underflow_d;
    logic              rx_push, rx_pop, rx_full, rx_empty, rx_ovf_ev;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [FW-1:0]     tx_rdata;

    // bit 3 is data: it only needs to line up with the bclk edge, not edge-detection
    always_comb begin
        sync1_d = {aud_adcdat, aud_daclrc, aud_adclrc, aud_bclk};
        sync2_d = sync1_q;
        sync3_d = sync2_q[2:0];
    end

    assign bclk_rise = sync2_q[0] & ~sync3_q[0];
    assign bclk_fall = ~sync2_q[0] & sync3_q[0];
    assign adc_rise  = sync2_q[1] & ~sync3_q[1];
    assign adc_fall  = ~sync2_q[1] & sync3_q[1];
    assign dac_rise  = sync2_q[2] & ~sync3_q[2];
    assign dac_fall  = ~sync2_q[2] & sync3_q[2];
    assign adc_bit   = sync2_q[3];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_skip_d  = rx_skip_q;
        rx_word_d  = rx_word_q;
        rx_left_d  = rx_left_q;
        rx_frame_d = rx_frame_q;
        rx_push_d  = 1'b0;
        rx_restart = 1'b0;
        rx_sample  = 1'b0;
        if (!enable) begin
            rx_state_d = ST_IDLE;
        end else begin
            unique case (rx_state_q)
                ST_IDLE: if (adc_fall) begin
                    rx_state_d = ST_LEFT;
                    rx_restart = 1'b1;
                end
                ST_LEFT: if (adc_rise) begin
                    rx_state_d = ST_RIGHT;
                    rx_left_d  = rx_word_q;
                    rx_restart = 1'b1;
                end else if (bclk_rise) begin
                    rx_sample = 1'b1;
                end
                ST_RIGHT: if (adc_fall) begin
                    rx_state_d = ST_LEFT;
                    rx_frame_d = {rx_left_q, rx_word_q};
                    rx_push_d  = 1'b1;
                    rx_restart = 1'b1;
                end else if (bclk_rise) begin
                    rx_sample = 1'b1;
                end
                default: rx_state_d = ST_IDLE;
            endcase
            // clearing the word up front gives zero LSBs for short words
            if (rx_restart) begin
                rx_cnt_d  = '0;
                rx_skip_d = (JUSTIFY == 0);
                rx_word_d = '0;
            end else if (rx_sample) begin
                if (rx_skip_q) begin
                    rx_skip_d = 1'b0;
                end else if (rx_cnt_q < CW'(DATA_W)) begin
                    rx_word_d[CW'(DATA_W - 1) - rx_cnt_q] = adc_bit;
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        tx_right_d = tx_right_q;
        dacdat_d   = dacdat_q;
        tx_pop     = 1'b0;
        tx_unf_ev  = 1'b0;
        tx_start   = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        tx_word    = '0;
        if (!enable) begin
            tx_state_d = ST_IDLE;
            dacdat_d   = 1'b0;
        end else begin
            unique case (tx_state_q)
                ST_IDLE: if (dac_fall) begin
                    tx_state_d = ST_LEFT;
                    tx_start   = 1'b1;
                end
                ST_LEFT: if (dac_rise) begin
                    tx_state_d = ST_RIGHT;
                    tx_load    = 1'b1;
                    tx_word    = tx_right_q;
                end else if (bclk_fall) begin
                    tx_shift = 1'b1;
                end
                ST_RIGHT: if (dac_fall) begin
                    tx_state_d = ST_LEFT;
                    tx_start   = 1'b1;
                end else if (bclk_fall) begin
                    tx_shift = 1'b1;
                end
                default: tx_state_d = ST_IDLE;
            endcase
            if (tx_start) begin
                tx_load = 1'b1;
                if (tx_empty) begin
                    tx_unf_ev  = 1'b1;
                    tx_right_d = '0;
                end else begin
                    tx_pop     = 1'b1;
                    tx_word    = tx_rdata[FW-1:DATA_W];
                    tx_right_d = tx_rdata[DATA_W-1:0];
                end
            end
            // left-justified puts the MSB out on the LRC edge itself
            if (tx_load) begin
                if (JUSTIFY != 0) begin
                    dacdat_d = tx_word[DATA_W-1];
                    tx_sh_d  = {tx_word[DATA_W-2:0], 1'b0};
                    tx_cnt_d = CW'(1);
                end else begin
                    dacdat_d = 1'b0;
                    tx_sh_d  = tx_word;
                    tx_cnt_d = '0;
                end
            end else if (tx_shift) begin
                if (tx_cnt_q < CW'(DATA_W)) begin
                    dacdat_d = tx_sh_q[DATA_W-1];
                    tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end else begin
                    dacdat_d = 1'b0;
                end
            end
        end
    end

    assign rx_push   = rx_push_q & enable;
    assign rx_pop    = rx_valid & rx_ready;
    assign rx_ovf_ev = rx_push & rx_full & ~rx_pop;
    assign tx_push   = tx_valid & ~tx_full;

    always_comb begin
        rx_overflow_d  = (rx_overflow_q & ~clear_flags) | rx_ovf_ev;
        tx_underflow_d = (tx_underflow_q & ~clear_flags) | tx_unf_ev;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            sync3_q        <= '0;
            rx_state_q     <= ST_IDLE;
            rx_cnt_q       <= '0;
            rx_skip_q      <= 1'b0;
            rx_word_q      <= '0;
            rx_left_q      <= '0;
            rx_frame_q     <= '0;
            rx_push_q      <= 1'b0;
            tx_state_q     <= ST_IDLE;
            tx_cnt_q       <= '0;
            tx_sh_q        <= '0;
            tx_right_q     <= '0;
            dacdat_q       <= 1'b0;
            rx_overflow_q  <= 1'b0;
            tx_underflow_q <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_skip_q      <= rx_skip_d;
            rx_word_q      <= rx_word_d;
            rx_left_q      <= rx_left_d;
            rx_frame_q     <= rx_frame_d;
            rx_push_q      <= rx_push_d;
            tx_state_q     <= tx_state_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_sh_q        <= tx_sh_d;
            tx_right_q     <= tx_right_d;
            dacdat_q       <= dacdat_d;
            rx_overflow_q  <= rx_overflow_d;
            tx_underflow_q <= tx_underflow_d;
        end
    end

    audio_i2s_stream_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk_clk), .rst_n(reset_reset_n),
        .push(rx_push), .pop(rx_pop), .wdata(rx_frame_q),
        .rdata(rx_data), .level(rx_level),
        .full(rx_full), .empty(rx_empty)
    );

    audio_i2s_stream_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk_clk), .rst_n(reset_reset_n),
        .push(tx_push), .pop(tx_pop), .wdata(tx_data),
        .rdata(tx_rdata), .level(tx_level),
        .full(tx_full), .empty(tx_empty)
    );

    assign rx_valid     = ~rx_empty;
    assign tx_ready     = ~tx_full;
    assign aud_dacdat   = dacdat_q;
    assign rx_overflow  = rx_overflow_q;
    assign tx_underflow = tx_underflow_q;
endmodule

// File: tb/tb_audio_i2s_stream_if.sv
// Directed bench: a codec model drives 32-slot I2S frames at 16 clk per BCLK;
// a second instance with JUSTIFY=1 shares the stimulus for the DAC offset test.
module tb_audio_i2s_stream_if;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        aud_bclk, aud_adclrc, aud_daclrc, aud_adcdat;
    logic        enable, clear_flags, rx_ready, tx_valid;
    logic [47:0] tx_data;

    logic        aud_dacdat, rx_valid, tx_ready, rx_overflow, tx_underflow;
    logic [47:0] rx_data;
    logic [2:0]  rx_level, tx_level;

    logic        lj_dacdat, lj_rx_valid, lj_tx_ready, lj_rx_overflow, lj_tx_underflow;
    logic [47:0] lj_rx_data;
    logic [2:0]  lj_rx_level, lj_tx_level;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] cap, cap_lj;

    logic [23:0] lv [5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    logic [23:0] rv [5] = '{24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};

    always #5 clk_clk = ~clk_clk;

    audio_i2s_stream_if #(.DATA_W(24), .FIFO_DEPTH(4), .JUSTIFY(0)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .aud_bclk(aud_bclk), .aud_adclrc(aud_adclrc), .aud_daclrc(aud_daclrc),
        .aud_adcdat(aud_adcdat), .aud_dacdat(aud_dacdat),
        .enable(enable), .clear_flags(clear_flags),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_level(rx_level), .tx_level(tx_level),
        .rx_overflow(rx_overflow), .tx_underflow(tx_underflow)
    );

    audio_i2s_stream_if #(.DATA_W(24), .FIFO_DEPTH(4), .JUSTIFY(1)) dut_lj (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .aud_bclk(aud_bclk), .aud_adclrc(aud_adclrc), .aud_daclrc(aud_daclrc),
        .aud_adcdat(aud_adcdat), .aud_dacdat(lj_dacdat),
        .enable(enable), .clear_flags(clear_flags),
        .rx_data(lj_rx_data), .rx_valid(lj_rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(lj_tx_ready),
        .rx_level(lj_rx_level), .tx_level(lj_tx_level),
        .rx_overflow(lj_rx_overflow), .tx_underflow(lj_tx_underflow)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // one I2S frame; each slot samples DACDAT of both instances at the BCLK rise
    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        logic [23:0] w;
        for (int ch = 0; ch < 2; ch++) begin
            w = (ch == 0) ? l : r;
            for (int k = 0; k < 32; k++) begin
                aud_bclk   = 1'b0;
                aud_adclrc = (ch == 1);
                aud_daclrc = (ch == 1);
                aud_adcdat = (k >= 1 && k <= 24) ? w[24-k] : 1'b0;
                wait_clk(8);
                aud_bclk = 1'b1;
                cap      = {cap[62:0], aud_dacdat};
                cap_lj   = {cap_lj[62:0], lj_dacdat};
                wait_clk(8);
            end
        end
    endtask

    task automatic lrc_fall;
        aud_bclk   = 1'b0;
        aud_adclrc = 1'b0;
        aud_daclrc = 1'b0;
        aud_adcdat = 1'b0;
    endtask

    task automatic go_idle;
        enable = 1'b0;
        wait_clk(2);
        aud_adclrc = 1'b1;
        aud_daclrc = 1'b1;
        aud_bclk   = 1'b1;
        wait_clk(8);
        enable = 1'b1;
        wait_clk(8);
    endtask

    task automatic push_tx(input logic [47:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_clk);
        tx_valid = 1'b0;
    endtask

    task automatic pulse_clear;
        clear_flags = 1'b1;
        @(negedge clk_clk);
        clear_flags = 1'b0;
    endtask

    task automatic drain;
        rx_ready = 1'b1;
        wait_clk(6);
        rx_ready = 1'b0;
        @(negedge clk_clk);
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0;
        enable = 1'b0; clear_flags = 1'b0; rx_ready = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        aud_bclk = 1'b1; aud_adclrc = 1'b1; aud_daclrc = 1'b1; aud_adcdat = 1'b0;
        cap = '0; cap_lj = '0;
        wait_clk(3);
        checks++; if (aud_dacdat !== 1'b0) begin errors++; $display("FAIL rst_dacdat: got %b want 0", aud_dacdat); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 48'h0) begin errors++; $display("FAIL rst_rx_data: got %h want 0", rx_data); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
        checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL rst_rx_level: got %0d want 0", rx_level); end
        checks++; if (tx_level !== 3'd0) begin errors++; $display("FAIL rst_tx_level: got %0d want 0", tx_level); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rst_rx_overflow: got %b want 0", rx_overflow); end
        checks++; if (tx_underflow !== 1'b0) begin errors++; $display("FAIL rst_tx_underflow: got %b want 0", tx_underflow); end
        reset_reset_n = 1'b1;
        wait_clk(4);
        enable = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_rx_basic;
        int n;
        send_frame(24'hABCDEF, 24'h123456);
        lrc_fall();
        n = 0;
        while (!rx_valid && n < 12) begin
            @(negedge clk_clk);
            n++;
        end
        checks++; if (!rx_valid || n > 4) begin errors++; $display("FAIL rx_latency: got %0d clk valid=%b want <=4", n, rx_valid); end
        checks++; if (rx_data !== 48'hABCDEF123456) begin errors++; $display("FAIL rx_data: got %h want abcdef123456", rx_data); end
        checks++; if (rx_level !== 3'd1) begin errors++; $display("FAIL rx_level1: got %0d want 1", rx_level); end
        wait_clk(4);
        go_idle();
        rx_ready = 1'b1;
        @(negedge clk_clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pop_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_tx_shift;
        push_tx(48'h800001_7FFFFE);
        checks++; if (tx_level !== 3'd1) begin errors++; $display("FAIL tx_level1: got %0d want 1", tx_level); end
        send_frame(24'h0, 24'h0);
        checks++; if (cap[63:32] !== 32'h40000080) begin errors++; $display("FAIL tx_i2s_left: got %h want 40000080", cap[63:32]); end
        checks++; if (cap[31:0] !== 32'h3FFFFF00) begin errors++; $display("FAIL tx_i2s_right: got %h want 3fffff00", cap[31:0]); end
        checks++; if (cap_lj[63:32] !== 32'h80000100) begin errors++; $display("FAIL tx_lj_left: got %h want 80000100", cap_lj[63:32]); end
        checks++; if (cap_lj[31:0] !== 32'h7FFFFE00) begin errors++; $display("FAIL tx_lj_right: got %h want 7ffffe00", cap_lj[31:0]); end
        go_idle();
    endtask

    task automatic test_underflow;
        pulse_clear();
        checks++; if (tx_underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b want 0", tx_underflow); end
        fork
            send_frame(24'h0, 24'h0);
            begin
                wait_clk(300);
                push_tx(48'hF0F0F0_0F0F0F);
            end
        join
        checks++; if (tx_underflow !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b want 1", tx_underflow); end
        checks++; if (cap !== 64'h0) begin errors++; $display("FAIL unf_zero_frame: got %h want 0", cap); end
        send_frame(24'h0, 24'h0);
        checks++; if (cap[63:32] !== 32'h78787800) begin errors++; $display("FAIL unf_next_left: got %h want 78787800", cap[63:32]); end
        checks++; if (cap[31:0] !== 32'h07878780) begin errors++; $display("FAIL unf_next_right: got %h want 07878780", cap[31:0]); end
        go_idle();
    endtask

    task automatic test_overflow;
        drain();
        checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL ovf_drain: got %0d want 0", rx_level); end
        for (int i = 0; i < 5; i++) send_frame(lv[i], rv[i]);
        lrc_fall();
        wait_clk(8);
        checks++; if (rx_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", rx_level); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", rx_overflow); end
        go_idle();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rx_data !== {lv[j], rv[j]}) begin
                errors++;
                $display("FAIL ovf_frame%0d: got %h want %h", j, rx_data, {lv[j], rv[j]});
            end
            rx_ready = 1'b1;
            @(negedge clk_clk);
            rx_ready = 1'b0;
        end
        pulse_clear();
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", rx_overflow); end
    endtask

    task automatic test_reset_midframe;
        push_tx(48'hFFFFFF_FFFFFF);
        push_tx(48'hFFFFFF_FFFFFF);
        fork
            send_frame(24'h0F0F0F, 24'h0F0F0F);
            begin
                wait_clk(16 * 10 + 12);
                checks++; if (aud_dacdat !== 1'b1) begin errors++; $display("FAIL rstmid_pre_dacdat: got %b want 1", aud_dacdat); end
                reset_reset_n = 1'b0;
                #1;
                checks++; if (aud_dacdat !== 1'b0) begin errors++; $display("FAIL rstmid_dacdat: got %b want 0", aud_dacdat); end
                checks++; if (tx_level !== 3'd0) begin errors++; $display("FAIL rstmid_tx_level: got %0d want 0", tx_level); end
                checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready); end
                wait_clk(3);
                reset_reset_n = 1'b1;
            end
        join
        send_frame(24'h13579B, 24'h2468AC);
        lrc_fall();
        wait_clk(8);
        checks++; if (rx_level !== 3'd1) begin errors++; $display("FAIL rstmid_rx_level: got %0d want 1", rx_level); end
        checks++; if (rx_data !== 48'h13579B2468AC) begin errors++; $display("FAIL rstmid_rx_data: got %h want 13579b2468ac", rx_data); end
        go_idle();
        drain();
    endtask

    task automatic test_enable;
        fork
            send_frame(24'h0A0A0A, 24'h0B0B0B);
            begin
                wait_clk(16 * 10);
                enable = 1'b0;
                wait_clk(16 * 30);
                enable = 1'b1;
            end
        join
        send_frame(24'hC0FFEE, 24'hBADA55);
        lrc_fall();
        wait_clk(8);
        checks++; if (rx_level !== 3'd1) begin errors++; $display("FAIL en_rx_level: got %0d want 1", rx_level); end
        checks++; if (rx_data !== 48'hC0FFEEBADA55) begin errors++; $display("FAIL en_rx_data: got %h want c0ffeebada55", rx_data); end
        go_idle();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rx_basic();
        test_tx_shift();
        test_underflow();
        test_overflow();
        test_reset_midframe();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
